// File: rtl/mc_mem_pkg.sv
// Shared types for the multicycle-CPU memory responder.
// The fault helper is only referenced when MC_MEM_ERR_CHECK_EN is defined.
package mc_mem_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

   typedef struct packed {
      logic              we;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wd;
   } mem_req_t;

   // Misaligned byte address, or a word index beyond the array.
   function automatic logic addr_fault(input logic [WORD_W-1:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= 32'(depth));
   endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Word RAM: synchronous write, combinational read, no reset so contents survive rst.
module mc_mem_array
   import mc_mem_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle MIPS datapath: req/ready slave with LATENCY wait states.
// Optional access-fault reporting is enabled with the MC_MEM_ERR_CHECK_EN macro.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on acceptance
// WAIT  | counting down wait states, inputs ignored
// RESP  | ready (and rd/err) presented for one cycle; write commits at its closing edge
module mc_mem_responder
   import mc_mem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wd,
   output logic [WORD_W-1:0] rd,
   output logic              ready,
   output logic              err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   mem_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   mem_req_t          req_q, req_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [WORD_W-1:0] rd_q, rd_d;

   logic [WORD_W-1:0] mem_rdata;
   logic              mem_we;
   logic              fault_next;
   logic              fault_cur;

`ifdef MC_MEM_ERR_CHECK_EN
   assign fault_next = addr_fault(req_d.addr, DEPTH);
   assign fault_cur  = addr_fault(req_q.addr, DEPTH);
`else
   logic unused_addr_bits;
   assign fault_next       = 1'b0;
   assign fault_cur        = 1'b0;
   assign unused_addr_bits = ^{req_d.addr[WORD_W-1:AW+2], req_d.addr[1:0],
                               req_q.addr[WORD_W-1:AW+2], req_q.addr[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rd_d    = '0;
      case (state_q)
         IDLE: begin
            if (req) begin
               req_d = '{we: we, addr: addr, wd: wd};
               if (LATENCY == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are registered on entry to RESP, so they use the request as it will be latched.
      if (state_d == RESP) begin
         ready_d = 1'b1;
         err_d   = fault_next;
         rd_d    = (!req_d.we && !fault_next) ? mem_rdata : '0;
      end
   end

   assign mem_we = (state_q == RESP) && req_q.we && !fault_cur;

   mc_mem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (req_q.addr[AW+1:2]),
      .wdata (req_q.wd),
      .raddr (req_d.addr[AW+1:2]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end

   assign ready = ready_q;
   assign err   = err_q;
   assign rd    = rd_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder; expectations come from an array model of the RAM.
module tb_mc_mem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wd    = '0;
   wire  [31:0] rd;
   wire         ready;
   wire         err;

   always #5 clk = ~clk;

   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(rst_n), .req(req), .we(we), .addr(addr), .wd(wd),
      .rd(rd), .ready(ready), .err(err)
   );

   // extra instances for the latency sweep (LATENCY 0, 1, 5)
   logic [2:0]  req_s   = '0;
   wire  [2:0]  rdy_s;
   wire  [2:0]  err_s;
   wire  [31:0] rd_s0, rd_s1, rd_s2;
   logic        zero_b  = 1'b0;
   logic [31:0] zero_w  = '0;
   logic [31:0] sw_addr = 32'h10;

   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
      .clk(clk), .reset(rst_n), .req(req_s[0]), .we(zero_b), .addr(sw_addr), .wd(zero_w),
      .rd(rd_s0), .ready(rdy_s[0]), .err(err_s[0]));
   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(rst_n), .req(req_s[1]), .we(zero_b), .addr(sw_addr), .wd(zero_w),
      .rd(rd_s1), .ready(rdy_s[1]), .err(err_s[1]));
   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(5)) u_l5 (
      .clk(clk), .reset(rst_n), .req(req_s[2]), .we(zero_b), .addr(sw_addr), .wd(zero_w),
      .rd(rd_s2), .ready(rdy_s[2]), .err(err_s[2]));

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [DEPTH];
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   bit          prev_rdy = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic bit is_fault(input logic [31:0] a);
`ifdef MC_MEM_ERR_CHECK_EN
      return (a % 4 != 0) || (a / 4 >= DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   // Push the expected response and apply the access to the reference RAM.
   task automatic expect_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input int rdy_cyc);
      exp_t e;
      bit   f;
      f     = is_fault(a);
      e.err = f;
      e.rd  = (w || f) ? 32'h0 : model[idx_of(a)];
      e.cyc = rdy_cyc;
      if (w && !f) model[idx_of(a)] = d;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 40);
      if (!ready) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   // req sampled at edge N -> ready observed after edge N+LAT (cycle N+LAT+1)
   task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wd = d;
      expect_access(w, a, d, cyc + 1 + LAT);
      wait_ready("access");
      req = 1'b0; we = 1'b0;
   endtask

   task automatic back_to_back(input logic [31:0] a1, input logic [31:0] a2);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a1;
      expect_access(1'b0, a1, 32'h0, cyc + 1 + LAT);
      wait_ready("b2b_first");
      addr = a2;
      expect_access(1'b0, a2, 32'h0, cyc + 2 + LAT);
      wait_ready("b2b_second");
      req = 1'b0;
   endtask

   task automatic sweep_one(input int k, input int lat);
      int s;
      int n = 0;
      @(negedge clk);
      req_s[k] = 1'b1;
      s = cyc + 1;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy_s[k] && n < 40);
      check($sformatf("sweep_lat%0d", lat), 32'(cyc - s), 32'(lat));
      req_s[k] = 1'b0;
      @(negedge clk);
      check($sformatf("sweep_pulse%0d", lat), {31'd0, rdy_s[k]}, 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_rdy = 1'b0;
      end else begin
         if (ready) begin
            check("ready_width", {31'd0, prev_rdy}, 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_ready", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("rd", rd, e.rd);
               check("err", {31'd0, err}, {31'd0, e.err});
               check("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else begin
            check("rd_idle_zero", rd, 32'h0);
         end
         prev_rdy = ready;
      end
   end

   initial begin
      bit          saw;
      int          n;
      logic [31:0] a;
      int          pick;

      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_rd", rd, 32'h0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom);

      access(1'b1, 32'h10, 32'hDEADBEEF);
      access(1'b0, 32'h10, 32'h0);
      access(1'b0, 32'h100, 32'h0);
      access(1'b0, 32'h103, 32'h0);
      access(1'b1, 32'h400, 32'hAAAA5555);
      access(1'b0, 32'h0, 32'h0);
      back_to_back(32'h10, 32'h14);

      for (int i = 0; i < 150; i++) begin
         pick = $urandom_range(0, 3);
         case (pick)
            0:       a = $urandom;
            1:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
            default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
         endcase
         access(1'($urandom_range(0, 1)), a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // reset while a write sits in WAIT: no response, RAM untouched
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h12345678;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ready) saw = 1'b1;
      end
      check("abort_no_ready", {31'd0, saw}, 32'd0);
      access(1'b0, 32'h20, 32'h0);

      sweep_one(0, 0);
      sweep_one(1, 1);
      sweep_one(2, 5);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
